// File: rtl/mem_pkg.sv
// mem_pkg -- shared definitions for the two-requester memory arbiter.
//
// Contents:
//   REQ0, REQ1 : requester indices, typed as 1-bit so they can index
//                two-entry vectors directly.
//   state_t    : read-tracking FSM encoding (IDLE = no read outstanding,
//                RD = a read was issued on the previous cycle).
package mem_pkg;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   typedef enum logic {
      IDLE = 1'b0,
      RD   = 1'b1
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2 -- two-way round-robin grant selection (purely combinational).
//
// Ports:
//   ptr   : in  1 bit, preferred requester when both are valid
//   valid : in  2 bits, request valid per requester (bit k = requester k)
//   gnt   : out 2 bits, one-hot grant, or zero when nobody is valid
//
// A lone valid requester is always granted; the pointer only breaks ties.
module rr_arb2
   import mem_pkg::*;
(
   input  logic       ptr,
   input  logic [1:0] valid,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = valid;
      if (&valid) begin
         gnt = 2'b00;
         gnt[ptr ? REQ1 : REQ0] = 1'b1;
      end
   end

endmodule

// File: rtl/mem_arb.sv
// mem_arb -- round-robin arbiter giving two requesters access to one
// external single-port synchronous memory (read data registered in the
// memory, one cycle of latency).
//
// Ports:
//   i_w_clk, i_w_rst_n            : clock, asynchronous active-low reset
//   i_w_reqk_valid/we/addr/wdata  : access request from requester k (k = 0, 1)
//   o_w_reqk_ready                : request accepted this cycle (combinational)
//   o_w_rspk_valid/rdata          : one-cycle read response for requester k
//   o_w_mem_cs/we/addr/wdata      : memory command, combinational from the grant
//   i_w_mem_rdata                 : registered read data from the memory
//   o_w_gnt0_cnt, o_w_gnt1_cnt    : 16-bit wrapping transfer counters, present
//                                   only when MEM_ARB_STATS_EN is defined
//
// Optional feature macro: MEM_ARB_STATS_EN (grant statistics counters).
module mem_arb
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  i_w_clk,
   input  logic                  i_w_rst_n,

   input  logic                  i_w_req0_valid,
   output logic                  o_w_req0_ready,
   input  logic                  i_w_req0_we,
   input  logic [ADDR_WIDTH-1:0] i_w_req0_addr,
   input  logic [DATA_WIDTH-1:0] i_w_req0_wdata,
   output logic                  o_w_rsp0_valid,
   output logic [DATA_WIDTH-1:0] o_w_rsp0_rdata,

   input  logic                  i_w_req1_valid,
   output logic                  o_w_req1_ready,
   input  logic                  i_w_req1_we,
   input  logic [ADDR_WIDTH-1:0] i_w_req1_addr,
   input  logic [DATA_WIDTH-1:0] i_w_req1_wdata,
   output logic                  o_w_rsp1_valid,
   output logic [DATA_WIDTH-1:0] o_w_rsp1_rdata,

   output logic                  o_w_mem_cs,
   output logic                  o_w_mem_we,
   output logic [ADDR_WIDTH-1:0] o_w_mem_addr,
   output logic [DATA_WIDTH-1:0] o_w_mem_wdata,
   input  logic [DATA_WIDTH-1:0] i_w_mem_rdata
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [15:0]           o_w_gnt0_cnt,
   output logic [15:0]           o_w_gnt1_cnt
`endif
);

   // Requests packed per index so the datapath can be selected by grant.
   logic [1:0]            req_valid;
   logic [1:0]            req_we;
   logic [ADDR_WIDTH-1:0] req_addr  [2];
   logic [DATA_WIDTH-1:0] req_wdata [2];

   logic [1:0]            gnt;
   logic                  any_xfer;
   logic                  sel;

   state_t                state_reg, state_next;
   logic                  ptr_reg, ptr_next;
   logic                  owner_reg, owner_next;
   logic                  rsp_active;

   logic [1:0]            rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata [2];

   assign req_valid    = {i_w_req1_valid, i_w_req0_valid};
   assign req_we       = {i_w_req1_we, i_w_req0_we};
   assign req_addr[0]  = i_w_req0_addr;
   assign req_addr[1]  = i_w_req1_addr;
   assign req_wdata[0] = i_w_req0_wdata;
   assign req_wdata[1] = i_w_req1_wdata;

   // Valids are masked by reset so that nothing is granted, and no memory
   // command escapes, while reset is held.
   rr_arb2 u_rr_arb2 (
      .ptr   (ptr_reg),
      .valid (req_valid & {2{i_w_rst_n}}),
      .gnt   (gnt)
   );

   assign any_xfer = |gnt;
   assign sel      = gnt[REQ1];

   always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
      if (!i_w_rst_n) begin
         state_reg <= IDLE;
         ptr_reg   <= REQ0;
         owner_reg <= REQ0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         owner_reg <= owner_next;
      end
   end

   // Next state depends only on this cycle's transfer: a read moves to RD
   // from either state, anything else returns to IDLE. A new read may be
   // issued while the previous one's data is being returned.
   always_comb begin
      state_next    = IDLE;
      ptr_next      = ptr_reg;
      owner_next    = owner_reg;
      rsp_active    = 1'b0;
      o_w_mem_cs    = 1'b0;
      o_w_mem_we    = 1'b0;
      o_w_mem_addr  = '0;
      o_w_mem_wdata = '0;

      case (state_reg)
         RD:      rsp_active = 1'b1;
         default: rsp_active = 1'b0;
      endcase

      if (any_xfer) begin
         o_w_mem_cs    = 1'b1;
         o_w_mem_we    = req_we[sel];
         o_w_mem_addr  = req_addr[sel];
         o_w_mem_wdata = req_wdata[sel];
         ptr_next      = ~sel;
         if (!req_we[sel]) begin
            state_next = RD;
            owner_next = sel;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rsp
         localparam logic IDX = (gi == 1) ? REQ1 : REQ0;
         assign rsp_valid[gi] = rsp_active && (owner_reg == IDX);
         assign rsp_rdata[gi] = rsp_valid[gi] ? i_w_mem_rdata : '0;
      end
   endgenerate

   assign o_w_req0_ready = gnt[REQ0];
   assign o_w_req1_ready = gnt[REQ1];
   assign o_w_rsp0_valid = rsp_valid[0];
   assign o_w_rsp1_valid = rsp_valid[1];
   assign o_w_rsp0_rdata = rsp_rdata[0];
   assign o_w_rsp1_rdata = rsp_rdata[1];

`ifdef MEM_ARB_STATS_EN
   generate
      for (gi = 0; gi < 2; gi++) begin : g_cnt
         logic [15:0] cnt_reg;
         // Natural 16-bit overflow gives the 0xFFFF -> 0x0000 wrap.
         always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
            if (!i_w_rst_n) begin
               cnt_reg <= '0;
            end else if (gnt[gi]) begin
               cnt_reg <= cnt_reg + 16'd1;
            end
         end
      end
   endgenerate

   assign o_w_gnt0_cnt = g_cnt[0].cnt_reg;
   assign o_w_gnt1_cnt = g_cnt[1].cnt_reg;
`endif

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, giving the address width on all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, giving the data width on all ports.
REQ-003 SHALL have port i_w_clk, input, 1 bit: single clock; all state updates on posedge.
REQ-004 SHALL have port i_w_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have, for k in {0,1}, port i_w_reqk_valid, input, 1 bit: requester k presents an access.
REQ-006 SHALL have port o_w_reqk_ready, output, 1 bit: access accepted this cycle.
REQ-007 SHALL have port i_w_reqk_we, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port i_w_reqk_addr, input, ADDR_WIDTH bits: access address.
REQ-009 SHALL have port i_w_reqk_wdata, input, DATA_WIDTH bits: write data.
REQ-010 SHALL have port o_w_rspk_valid, output, 1 bit: one-cycle pulse, read data for k valid.
REQ-011 SHALL have port o_w_rspk_rdata, output, DATA_WIDTH bits: read data.
REQ-012 SHALL have ports o_w_mem_cs, o_w_mem_we, o_w_mem_addr and o_w_mem_wdata, all outputs, driving the single-port synchronous memory.
REQ-013 SHALL have port i_w_mem_rdata, input, DATA_WIDTH bits: memory read data, registered inside the memory, valid one cycle after a read.

Function
REQ-014 SHALL grant at most one requester per cycle.
REQ-015 SHALL assert o_w_reqk_ready combinationally only when i_w_reqk_valid=1 and k is granted; a transfer is valid&&ready.
REQ-016 SHALL drive o_w_mem_* combinationally from the granted request, with cs=1 only on a transfer; otherwise cs=0, we=0, addr=0, wdata=0.
REQ-017 SHALL arbitrate round-robin: a 1-bit pointer names the preferred requester; on a transfer by k, the pointer becomes !k; with no transfer, the pointer holds.
REQ-018 SHALL grant the single valid requester regardless of the pointer.
REQ-019 SHALL use a two-state FSM: IDLE (no read outstanding) and RD (read issued last cycle); transfer with we=0 -> RD; otherwise -> IDLE, from either state.
REQ-020 SHALL, in RD, pulse o_w_rspk_valid=1 for the requester k recorded at issue, with o_w_rspk_rdata = i_w_mem_rdata (read latency exactly 1 cycle).
REQ-021 SHALL keep o_w_rspk_rdata at 0 when o_w_rspk_valid=0.
REQ-022 SHALL allow a new transfer in RD (back-to-back reads: one read per cycle, full throughput).
REQ-023 SHALL never pulse a response for a write.
REQ-024 SHALL, for a write at cycle N followed by a read of the same address at N+1, return the new data at N+2.
REQ-025 SHALL allow a requester to change its request while it is not granted (no hold requirement); the arbiter carries no state for an ungranted request.

Reset
REQ-026 SHALL, while i_w_rst_n=0, force state=IDLE, pointer=0, all ready=0, all rsp_valid=0, all rsp_rdata=0, o_w_mem_cs=0 and the other o_w_mem_* outputs to 0.
REQ-027 SHALL discard a read outstanding when reset asserts mid-operation; no response follows reset release.
REQ-028 SHALL accept transfers from the first posedge after release.

Configuration
REQ-029 SHALL, with MEM_ARB_STATS_EN defined, add outputs o_w_gnt0_cnt and o_w_gnt1_cnt, each 16 bits.
REQ-030 SHALL increment o_w_gntk_cnt by 1 on every transfer by k, wrapping 0xFFFF -> 0x0000, and reset it to 0.
REQ-031 SHALL, without MEM_ARB_STATS_EN, omit these ports and counters, with identical behaviour otherwise.

Structure
REQ-032 SHALL place in shared package mem_pkg the requester index constants REQ0=0 and REQ1=1 and the FSM state encoding (IDLE=0, RD=1).
REQ-033 SHALL place grant selection (pointer + valids -> one-hot grant) in sub-module rr_arb2.
REQ-034 SHALL keep the memory external; mem_arb does not instantiate the memory.

Verification
REQ-035 SHALL cover: req0 write addr 0x10 data 0xA5, then req0 read 0x10 -> rsp0_valid one pulse 2 cycles after write, rdata 0xA5; rsp1_valid stays 0.
REQ-036 SHALL cover: both valid continuously for 4 cycles after reset -> grants alternate 0,1,0,1; each ready high exactly 2 cycles.
REQ-037 SHALL cover: only req1 valid for 3 cycles -> req1 granted every cycle; pointer ends at 0.
REQ-038 SHALL cover: back-to-back reads req0 addr 1, req1 addr 2 (contents 0x11, 0x22) -> rsp0 0x11 then rsp1 0x22 on consecutive cycles.
REQ-039 SHALL cover: read issued, reset asserted the next cycle before the posedge -> no rsp_valid; all outputs 0; normal operation after release.
REQ-040 SHALL cover: with MEM_ARB_STATS_EN, 65537 req0 transfers -> o_w_gnt0_cnt = 1 and o_w_gnt1_cnt = 0.
